// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard scoreboard unit.
//   lat_class_e : latency class of the instruction sitting in ID
//   sb_cnt_w()  : width of a scoreboard countdown for the given latencies
//   DEF_*       : default load / MUL-DIV consumer bubble counts
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      LAT_NONE,
      LAT_LOAD,
      LAT_MULDIV
   } lat_class_e;

   localparam int unsigned DEF_LOAD_LAT   = 1;
   localparam int unsigned DEF_MULDIV_LAT = 4;

   // Countdown must hold the larger of the two latencies.
   function automatic int unsigned sb_cnt_w(input int unsigned load_lat,
                                            input int unsigned muldiv_lat);
      int unsigned max_lat;
      max_lat = (load_lat > muldiv_lat) ? load_lat : muldiv_lat;
      return $clog2(max_lat + 1);
   endfunction

   localparam int unsigned SB_CNT_W = sb_cnt_w(DEF_LOAD_LAT, DEF_MULDIV_LAT);

endpackage

// File: rtl/hazard_sb_entry.sv
// -----------------------------------------------------------------------------
// hazard_sb_entry
// One scoreboard slot: countdown of bubbles still owed to a consumer of this
// register, plus a flag recording whether the pending producer is a load.
//   clk, reset   : clock, synchronous active-high reset
//   load_en      : an issuing long-latency producer targets this register
//   load_val     : countdown start value
//   load_is_load : producer is a load
//   cnt          : current countdown
//   is_load      : pending producer is a load
// -----------------------------------------------------------------------------
module hazard_sb_entry #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_en,
   input  logic [W-1:0] load_val,
   input  logic         load_is_load,
   output logic [W-1:0] cnt,
   output logic         is_load
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         is_load_q, is_load_d;

   // A new issue overrides the decrement happening in the same cycle.
   always_comb begin
      cnt_d     = cnt_q;
      is_load_d = is_load_q;
      if (load_en) begin
         cnt_d     = load_val;
         is_load_d = load_is_load;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         is_load_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         is_load_q <= is_load_d;
      end
   end

   assign cnt     = cnt_q;
   assign is_load = is_load_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_unit
// Load-use / MUL-DIV RAW+WAW / MUL-DIV structural hazard detection and
// branch-flush control for the pipelined core.
//   clk, reset                 : clock, synchronous active-high reset
//   VALID_ID                   : ID holds a real instruction
//   RS1_ID, RS2_ID, RD_ID      : register indices of the ID instruction
//   USES_RS1_ID, USES_RS2_ID   : sources actually read
//   REGWRITE_ID, MEMREAD_ID,
//   MEMWRITE_ID, MULDIV_ID     : ID instruction class
//   BRANCHTAKEN_EX             : taken branch/jump resolved in EX
//   PCWrite, stall_IF_ID,
//   flush_IF_ID, flush_ID_EX   : pipeline control
//   stall_count                : saturating count of hazard-stall cycles
//   sb_busy                    : some scoreboard countdown is non-zero
// -----------------------------------------------------------------------------
module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned LOAD_LAT   = DEF_LOAD_LAT,
   parameter int unsigned MULDIV_LAT = DEF_MULDIV_LAT,
   parameter int unsigned STORE_FWD  = 1,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  VALID_ID,
   input  logic [REG_ADDR_W-1:0] RS1_ID,
   input  logic [REG_ADDR_W-1:0] RS2_ID,
   input  logic                  USES_RS1_ID,
   input  logic                  USES_RS2_ID,
   input  logic [REG_ADDR_W-1:0] RD_ID,
   input  logic                  REGWRITE_ID,
   input  logic                  MEMREAD_ID,
   input  logic                  MEMWRITE_ID,
   input  logic                  MULDIV_ID,
   input  logic                  BRANCHTAKEN_EX,
   output logic                  PCWrite,
   output logic                  stall_IF_ID,
   output logic                  flush_IF_ID,
   output logic                  flush_ID_EX,
   output logic [CNT_W-1:0]      stall_count,
   output logic                  sb_busy
);

   localparam int unsigned SBW = sb_cnt_w(LOAD_LAT, MULDIV_LAT);

   logic [SBW-1:0]   cnt     [NUM_REGS];
   logic             is_load [NUM_REGS];
   logic [SBW-1:0]   md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   lat_class_e       id_class;
   logic [SBW-1:0]   id_lat;
   logic             raw1, raw2, waw, structural, hazard, issue;
   logic             sb_load_en, stall_sel;

   // x0 has no slot; it reads as permanently ready.
   assign cnt[0]     = '0;
   assign is_load[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
      hazard_sb_entry #(.W(SBW)) u_entry (
         .clk          (clk),
         .reset        (reset),
         .load_en      (sb_load_en && (RD_ID == REG_ADDR_W'(r))),
         .load_val     (id_lat),
         .load_is_load (MEMREAD_ID),
         .cnt          (cnt[r]),
         .is_load      (is_load[r])
      );
   end

   // Hazard detection
   always_comb begin
      id_class = LAT_NONE;
      if (MEMREAD_ID)     id_class = LAT_LOAD;
      else if (MULDIV_ID) id_class = LAT_MULDIV;

      case (id_class)
         LAT_LOAD:   id_lat = SBW'(LOAD_LAT);
         LAT_MULDIV: id_lat = SBW'(MULDIV_LAT);
         default:    id_lat = '0;
      endcase

      raw1 = USES_RS1_ID && (RS1_ID != '0) && (cnt[RS1_ID] != '0);
      raw2 = USES_RS2_ID && (RS2_ID != '0) && (cnt[RS2_ID] != '0);
      // Store data of a load with one cycle left is forwarded MEM->MEM.
      if ((STORE_FWD != 0) && MEMWRITE_ID && is_load[RS2_ID] && (cnt[RS2_ID] == SBW'(1)))
         raw2 = 1'b0;

      // WAW only if the older write would land after ours.
      waw        = REGWRITE_ID && (RD_ID != '0) && (cnt[RD_ID] > id_lat);
      structural = MULDIV_ID && (md_cnt_q != '0);
      hazard     = VALID_ID && (raw1 || raw2 || waw || structural);
      issue      = VALID_ID && !hazard && !BRANCHTAKEN_EX;
      sb_load_en = issue && REGWRITE_ID && (RD_ID != '0) && (id_class != LAT_NONE);
      stall_sel  = !reset && !BRANCHTAKEN_EX && hazard;
   end

   // Next-state for MUL/DIV occupancy and stall counter
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (issue && MULDIV_ID)  md_cnt_d = SBW'(MULDIV_LAT);
      else if (md_cnt_q != '0) md_cnt_d = md_cnt_q - 1'b1;

      stall_count_d = stall_count_q;
      if (stall_sel && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q      <= '0;
         stall_count_q <= '0;
      end else begin
         md_cnt_q      <= md_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Output priority: reset, branch, hazard, normal
   always_comb begin
      PCWrite     = 1'b1;
      stall_IF_ID = 1'b0;
      flush_IF_ID = 1'b0;
      flush_ID_EX = 1'b0;
      if (reset || BRANCHTAKEN_EX) begin
         flush_IF_ID = 1'b1;
         flush_ID_EX = 1'b1;
      end else if (hazard) begin
         PCWrite     = 1'b0;
         stall_IF_ID = 1'b1;
         flush_ID_EX = 1'b1;
      end
   end

   always_comb begin
      sb_busy = 1'b0;
      for (int unsigned r = 1; r < NUM_REGS; r++)
         if (cnt[r] != '0) sb_busy = 1'b1;
   end

   assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Parametrised hazard unit for the pipelined RISC-V core. It handles load-use hazards for configurable memory latency, multi-cycle MUL/DIV RAW and WAW hazards, a non-pipelined MUL/DIV structural hazard, and branch-taken flushes. A per-register countdown scoreboard sits between decode (ID) and execute (EX), and the block drives PC/IF-ID stall and IF-ID/ID-EX flush controls. A stall-cycle counter is exported for performance analysis.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers (x0 hard-wired zero)
- REG_ADDR_W, 5, register index width, = $clog2(NUM_REGS)
- LOAD_LAT, 1, bubbles a load consumer needs (≥1)
- MULDIV_LAT, 4, bubbles a MUL/DIV consumer needs (≥1)
- STORE_FWD, 1, 1 = store data (RS2) of a store exempt from a load hazard with 1 cycle remaining (MEM→MEM forwarding)
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- VALID_ID  in  1  ID holds a real instruction
- RS1_ID, RS2_ID  in  REG_ADDR_W  source indices
- USES_RS1_ID, USES_RS2_ID  in  1  source actually read
- RD_ID  in  REG_ADDR_W  destination index
- REGWRITE_ID  in  1  ID instruction writes RD
- MEMREAD_ID  in  1  ID instruction is a load
- MEMWRITE_ID  in  1  ID instruction is a store
- MULDIV_ID  in  1  ID instruction is MUL/DIV
- BRANCHTAKEN_EX  in  1  branch/jump in EX resolved taken
- PCWrite  out  1  PC update enable
- stall_IF_ID  out  1  hold IF/ID register
- flush_IF_ID  out  1  bubble IF/ID
- flush_ID_EX  out  1  bubble ID/EX
- stall_count  out  CNT_W  hazard-stall cycles since reset
- sb_busy  out  1  any scoreboard counter non-zero

## Operation
- Scoreboard: per register r, cnt[r] (width $clog2(max(LOAD_LAT,MULDIV_LAT)+1)) and is_load[r]. Entry 0 is never written.
- Issue: issue = VALID_ID & !hazard & !BRANCHTAKEN_EX. If issue & REGWRITE_ID & RD_ID≠0 & (MEMREAD_ID|MULDIV_ID): cnt[RD_ID] ← LOAD_LAT or MULDIV_LAT, is_load ← MEMREAD_ID. All other non-zero counters decrement by 1 every cycle.
- RAW: raw1 = USES_RS1_ID & RS1_ID≠0 & cnt[RS1_ID]≠0; raw2 likewise for RS2. If STORE_FWD & MEMWRITE_ID & is_load[RS2_ID] & cnt[RS2_ID]==1, raw2 = 0.
- WAW: REGWRITE_ID & RD_ID≠0 & cnt[RD_ID] > latency of the ID instruction (0 if short-latency).
- Structural: MULDIV_ID & md_cnt≠0. md_cnt is loaded with MULDIV_LAT on MUL/DIV issue and decrements to 0.
- hazard = VALID_ID & (raw1|raw2|waw|struct).
- Output priority (highest first):
  - reset: PCWrite=1, stall_IF_ID=0, flush_IF_ID=1, flush_ID_EX=1.
  - BRANCHTAKEN_EX: PCWrite=1, stall_IF_ID=0, flush_IF_ID=1, flush_ID_EX=1.
  - hazard: PCWrite=0, stall_IF_ID=1, flush_IF_ID=0, flush_ID_EX=1.
  - else: PCWrite=1, all others 0.
- stall_count increments in each cycle where the hazard branch is selected. It saturates at all-ones.

## Timing
- Control outputs are combinational from inputs and scoreboard state. The scoreboard, md_cnt and stall_count update on the rising clk edge.
- Load issued at cycle t: consumer in ID stalls cycles t+1..t+LOAD_LAT and issues at t+LOAD_LAT+1. MUL/DIV is the same with MULDIV_LAT.
- Reset (any cycle, including mid-stall): all cnt, is_load, md_cnt, stall_count ← 0 on the next edge. sb_busy=0 after reset.
- Simultaneous events:
  - Branch taken + hazard → branch wins, no issue, stall_count unchanged.
  - Issue to register r in the same cycle cnt[r] decrements → the new value wins.
  - Counter reaching 0 this cycle → the ID consumer still sees the pre-edge value and stalls this cycle.
- The ID instruction flushed by a branch never writes the scoreboard. Entries from older in-flight instructions keep counting.

## Structure
- Package hazard_pkg: lat_class_e enum (LAT_NONE, LAT_LOAD, LAT_MULDIV), SB_CNT_W localparam function, default latency constants.
- Sub-module hazard_sb_entry (one instance per register 1..NUM_REGS-1):
  - Holds the countdown plus is_load bit.
  - Ports: load_en, load_val, load_is_load, cnt, is_load.
- Top level holds the hazard compare, md_cnt, output priority mux and stall_count.

## Test plan
- LOAD_LAT=1: `lw x5` issues at t, `add x6,x5,x1` in ID at t+1 → exactly 1 stall cycle (PCWrite=0, flush_ID_EX=1), issue at t+2, stall_count=1.
- LOAD_LAT=3, load→use → 3 stall cycles. Same with STORE_FWD=1, `sw x5` at t+3 (cnt=1) → no stall on RS2.
- `mul x7` then `lw x7` next cycle → WAW stall until cnt[x7] ≤ 1. Then `div` while md_cnt=2 → structural stall for 2 cycles.
- Hazard present and BRANCHTAKEN_EX=1 in the same cycle → PCWrite=1, flush_IF_ID=1, flush_ID_EX=1, no scoreboard write, stall_count unchanged.
- Writes/reads of x0 with pending loads elsewhere → never stall. USES_RS2_ID=0 with RS2 matching a pending register → no stall.
- reset asserted mid MUL/DIV stall (cnt=3) → next cycle sb_busy=0 and stall_count=0; the consumer then issues with no stall.
